coherence_bus_arbiter: RTL and testbench

Two-core data-bus arbiter and snoop sequencer between the per-core dcaches and the single-ported RAM. It grants one dcache at a time and runs a snoop of the other dcache on every read. A dirty line held by the snooped cache is forwarded cache-to-cache while also being written back to RAM; otherwise the line is read from RAM. Writebacks from the granted cache go straight to RAM.

---
 rtl/coherence_bus_arbiter_pkg.sv | 7 +
 rtl/busarb_rr_select.sv | 22 ++
 rtl/coherence_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_bus_arbiter_pkg.sv
// coherence_bus_arbiter_pkg: shared FSM states and line/RAM handshake constants for the bus arbiter
package coherence_bus_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, SNOOP, FWD, MEM, WB} busarb_state_t;
    localparam int WORDS_PER_LINE = 2;
    localparam int WORD_OFF_BIT = 2;
    localparam logic RAM_BUSY = 1'b1;
endpackage

// File: rtl/busarb_rr_select.sv
// busarb_rr_select: 2-way grant select; round-robin when ARB_ROUND_ROBIN_EN is defined, else fixed priority to cache 0
module busarb_rr_select (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant
);
`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign grant = &req ? ~last_q : req[1];
    always_comb last_d = take ? grant : last_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) last_q <= 1'b1;
        else last_q <= last_d;
    end
`else
    logic unused_ok;
    assign grant = ~req[0];
    assign unused_ok = ^{CLK, nRST, take, req[1]};
`endif
endmodule

// File: rtl/coherence_bus_arbiter.sv
// coherence_bus_arbiter: two-core dcache bus arbiter and snoop sequencer; ARB_ROUND_ROBIN_EN selects round-robin grant
module coherence_bus_arbiter
    import coherence_bus_arbiter_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN        [CPUS],
    input  logic        dWEN        [CPUS],
    input  logic [31:0] daddr       [CPUS],
    input  logic [31:0] dstore      [CPUS],
    input  logic        ccwrite     [CPUS],
    input  logic        cctrans     [CPUS],
    output logic        dwait       [CPUS],
    output logic [31:0] dload       [CPUS],
    output logic        ccwait      [CPUS],
    output logic        ccinv       [CPUS],
    output logic [31:0] ccsnoopaddr [CPUS],
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramwait
);
    busarb_state_t state_q, state_d;
    logic g_q, g_d, ccinv_q, ccinv_d, word_q, word_d;
    logic o, sel, req_g, done, last_word;
    logic [1:0] req;

    assign o = ~g_q;
    assign req = {dREN[1] | dWEN[1], dREN[0] | dWEN[0]};
    assign req_g = dREN[g_q] | dWEN[g_q];
    assign last_word = word_q == 1'(WORDS_PER_LINE - 1);
    assign done = (ramwait != RAM_BUSY) && (state_q == MEM ? dREN[g_q] :
                  state_q == WB ? dWEN[g_q] : state_q == FWD && dWEN[o] && req_g);

    busarb_rr_select u_sel (
        .CLK(CLK),
        .nRST(nRST),
        .req(req),
        .take(state_q == IDLE && |req),
        .grant(sel)
    );

    always_comb begin
        state_d = state_q;
        g_d = g_q;
        ccinv_d = ccinv_q;
        word_d = done ? ~word_q : word_q;
        case (state_q)
            IDLE: begin
                word_d = 1'b0;
                if (|req) begin
                    g_d = sel;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = dWEN[g_q] ? WB : SNOOP;
                ccinv_d = ccwrite[g_q];
            end
            SNOOP: if (cctrans[o]) state_d = ccwrite[o] ? FWD : MEM;
            default: if (done && last_word) state_d = IDLE;
        endcase
        // an abandoned transaction returns to IDLE without further strobes
        if (state_q != IDLE && !req_g) state_d = IDLE;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            g_q <= 1'b0;
            ccinv_q <= 1'b0;
            word_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q <= g_d;
            ccinv_q <= ccinv_d;
            word_q <= word_d;
        end
    end

    always_comb begin
        dwait = '{default: 1'b1};
        dload = '{default: 32'h0};
        ccwait = '{default: 1'b0};
        ccinv = '{default: 1'b0};
        ccsnoopaddr = '{default: 32'h0};
        ramREN = 1'b0;
        ramWEN = 1'b0;
        ramaddr = '0;
        ramstore = '0;
        if (state_q == SNOOP || state_q == FWD) begin
            ccwait[o] = 1'b1;
            ccinv[o] = ccinv_q;
            ccsnoopaddr[o] = daddr[g_q];
        end
        if (state_q == FWD) begin
            ramWEN = dWEN[o] && req_g;
            ramaddr = daddr[o];
            ramstore = dstore[o];
            dload[g_q] = dstore[o];
            dwait[g_q] = !done;
            dwait[o] = !done;
        end
        if (state_q == MEM) begin
            ramREN = dREN[g_q];
            ramaddr = daddr[g_q];
            dload[g_q] = ramload;
            dwait[g_q] = !done;
        end
        if (state_q == WB) begin
            ramWEN = dWEN[g_q];
            ramaddr = daddr[g_q];
            ramstore = dstore[g_q];
            dwait[g_q] = !done;
        end
    end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// tb_coherence_bus_arbiter: scoreboard bench for coherence_bus_arbiter (either ARB_ROUND_ROBIN_EN setting)
module tb_coherence_bus_arbiter;
    localparam logic [31:0] K = 32'hCAFE_0000;
    typedef struct {logic [31:0] addr; logic [31:0] data;} exp_t;

    logic CLK = 1'b0, nRST = 1'b0;
    logic dREN [2], dWEN [2], ccwrite [2], cctrans [2];
    logic [31:0] daddr [2], dstore [2];
    logic dwait [2], ccwait [2], ccinv [2];
    logic [31:0] dload [2], ccsnoopaddr [2];
    logic ramREN, ramWEN, ramwait;
    logic [31:0] ramaddr, ramstore, ramload;
    int ram_lat = 0, ram_cnt = 0;
    int checks = 0, errors = 0;
    exp_t sb [$];
    int win_q [$];

    always #5 CLK = ~CLK;

    coherence_bus_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans), .dwait(dwait), .dload(dload), .ccwait(ccwait),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
    );

    // RAM model: ram_lat busy cycles per strobed word, data derived from address
    assign ramload = ramaddr ^ K;
    assign ramwait = (ramREN || ramWEN) && (ram_cnt < ram_lat);
    always @(posedge CLK) ram_cnt <= ((ramREN || ramWEN) && ram_cnt < ram_lat) ? ram_cnt + 1 : 0;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        for (int i = 0; i < 2; i++) begin
            dREN[i] = 1'b0; dWEN[i] = 1'b0; ccwrite[i] = 1'b0; cctrans[i] = 1'b0;
            daddr[i] = '0; dstore[i] = '0;
        end
    endtask

    task automatic do_reset;
        clear_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        nRST = 1'b0;
        #12;
        checks++;
        if ({dwait[0], dwait[1], ccwait[0], ccwait[1], ccinv[0], ccinv[1], ramREN, ramWEN} !== 8'b11000000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 11000000",
                {dwait[0], dwait[1], ccwait[0], ccwait[1], ccinv[0], ccinv[1], ramREN, ramWEN});
        end
        checks++;
        if ({dload[0], dload[1], ccsnoopaddr[0], ccsnoopaddr[1], ramaddr, ramstore} !== 192'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0",
                {dload[0], dload[1], ccsnoopaddr[0], ccsnoopaddr[1], ramaddr, ramstore});
        end
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({dwait[0], dwait[1], ramREN, ramWEN} !== 4'b1100) begin
            errors++; $display("FAIL idle_after_reset got %b exp 1100", {dwait[0], dwait[1], ramREN, ramWEN});
        end
    endtask

    task automatic test_mem_read;
        int words = 0, seen = 0;
        logic adv;
        exp_t e;
        ram_lat = 1;
        sb.push_back('{32'h100, 32'h100 ^ K});
        sb.push_back('{32'h104, 32'h104 ^ K});
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h100; cctrans[1] = 1'b1; ccwrite[1] = 1'b0;
        for (int c = 0; c < 30 && words < 2; c++) begin
            @(negedge CLK);
            adv = 1'b0;
            if (ccwait[1]) seen = 1;
            if (dwait[0] === 1'b0) begin
                e = sb.pop_front();
                checks++;
                if ({ramREN, ramaddr, dload[0], dwait[1]} !== {1'b1, e.addr, e.data, 1'b1}) begin
                    errors++; $display("FAIL mem_word got %h exp %h", {ramREN, ramaddr, dload[0], dwait[1]}, {1'b1, e.addr, e.data, 1'b1});
                end
                words++;
                adv = 1'b1;
            end
            tick();
            if (adv && words == 1) daddr[0] = 32'h104;
            if (adv && words == 2) clear_inputs();
        end
        checks++;
        if (words != 2 || seen != 1) begin
            errors++; $display("FAIL mem_done got words=%0d snoop=%0d exp 2 1", words, seen);
        end
        @(negedge CLK);
        checks++;
        if ({ramREN, dwait[0], ccwait[1]} !== 3'b010) begin
            errors++; $display("FAIL mem_idle got %b exp 010", {ramREN, dwait[0], ccwait[1]});
        end
    endtask

    task automatic test_fwd;
        int words = 0;
        logic adv, respond;
        exp_t e;
        ram_lat = 1;
        sb.push_back('{32'h200, 32'h0000AAAA});
        sb.push_back('{32'h204, 32'h0000BBBB});
        tick();
        dREN[1] = 1'b1; daddr[1] = 32'h200; ccwrite[1] = 1'b1;
        for (int c = 0; c < 30 && words < 2; c++) begin
            @(negedge CLK);
            adv = 1'b0;
            respond = 1'b0;
            if (ccwait[0] && !dWEN[0]) begin
                checks++;
                if ({ccinv[0], ccsnoopaddr[0], ramREN, ramWEN} !== {1'b1, 32'h200, 2'b00}) begin
                    errors++; $display("FAIL fwd_snoop got %h exp %h", {ccinv[0], ccsnoopaddr[0], ramREN, ramWEN}, {1'b1, 32'h200, 2'b00});
                end
                respond = 1'b1;
            end
            if (dwait[1] === 1'b0) begin
                e = sb.pop_front();
                checks++;
                if ({ramWEN, ramaddr, ramstore, dload[1], dwait[0], ccwait[0]} !== {1'b1, e.addr, e.data, e.data, 1'b0, 1'b1}) begin
                    errors++; $display("FAIL fwd_word got %h exp %h", {ramWEN, ramaddr, ramstore, dload[1], dwait[0], ccwait[0]},
                        {1'b1, e.addr, e.data, e.data, 1'b0, 1'b1});
                end
                words++;
                adv = 1'b1;
            end
            tick();
            if (respond) begin
                cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h0000AAAA;
            end
            if (adv && words == 1) begin
                daddr[0] = 32'h204; dstore[0] = 32'h0000BBBB; daddr[1] = 32'h204;
            end
            if (adv && words == 2) clear_inputs();
        end
        checks++;
        if (words != 2) begin
            errors++; $display("FAIL fwd_done got words=%0d exp 2", words);
        end
        @(negedge CLK);
        checks++;
        if ({ramWEN, ccwait[0], ccinv[0]} !== 3'b000) begin
            errors++; $display("FAIL fwd_idle got %b exp 000", {ramWEN, ccwait[0], ccinv[0]});
        end
    endtask

    task automatic test_wb;
        int words = 0, waits = 0, snooped = 0;
        logic adv;
        exp_t e;
        ram_lat = 3;
        sb.push_back('{32'h300, 32'h30000001});
        sb.push_back('{32'h304, 32'h30000002});
        tick();
        dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'h30000001;
        for (int c = 0; c < 40 && words < 2; c++) begin
            @(negedge CLK);
            adv = 1'b0;
            if (ccwait[0] || ccwait[1]) snooped = 1;
            if (ramWEN && dwait[0]) waits++;
            if (dwait[0] === 1'b0) begin
                e = sb.pop_front();
                checks++;
                if ({ramWEN, ramaddr, ramstore} !== {1'b1, e.addr, e.data} || waits != 3) begin
                    errors++; $display("FAIL wb_word got %h waits=%0d exp %h waits=3", {ramWEN, ramaddr, ramstore}, waits, {1'b1, e.addr, e.data});
                end
                waits = 0;
                words++;
                adv = 1'b1;
            end
            tick();
            if (adv && words == 1) begin
                daddr[0] = 32'h304; dstore[0] = 32'h30000002;
            end
            if (adv && words == 2) clear_inputs();
        end
        checks++;
        if (words != 2 || snooped != 0) begin
            errors++; $display("FAIL wb_done got words=%0d snoop=%0d exp 2 0", words, snooped);
        end
    endtask

    task automatic test_snoop_delay;
        int words = 0, snoop_cycles = 0, strobe = 0;
        logic adv, respond;
        exp_t e;
        ram_lat = 0;
        sb.push_back('{32'h140, 32'h140 ^ K});
        sb.push_back('{32'h144, 32'h144 ^ K});
        tick();
        dREN[0] = 1'b1; daddr[0] = 32'h140;
        for (int c = 0; c < 40 && words < 2; c++) begin
            @(negedge CLK);
            adv = 1'b0;
            respond = 1'b0;
            if (ccwait[1] && !cctrans[1]) begin
                snoop_cycles++;
                if (ramREN || ramWEN) strobe = 1;
                if (snoop_cycles == 4) respond = 1'b1;
            end
            if (dwait[0] === 1'b0) begin
                e = sb.pop_front();
                checks++;
                if ({ramREN, ramaddr, dload[0]} !== {1'b1, e.addr, e.data}) begin
                    errors++; $display("FAIL delay_word got %h exp %h", {ramREN, ramaddr, dload[0]}, {1'b1, e.addr, e.data});
                end
                words++;
                adv = 1'b1;
            end
            tick();
            if (respond) begin
                cctrans[1] = 1'b1; ccwrite[1] = 1'b0;
            end
            if (adv && words == 1) daddr[0] = 32'h144;
            if (adv && words == 2) clear_inputs();
        end
        checks++;
        if (words != 2 || snoop_cycles != 4 || strobe != 0) begin
            errors++; $display("FAIL delay_done got words=%0d snoop=%0d strobe=%0d exp 2 4 0", words, snoop_cycles, strobe);
        end
    endtask

    task automatic test_reset_mid;
        int hit = 0, words = 0, first = -1;
        logic respond, adv;
        exp_t e;
        ram_lat = 5;
        tick();
        dREN[1] = 1'b1; daddr[1] = 32'h600; ccwrite[1] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (ramWEN) begin
                hit = 1;
                break;
            end
            respond = ccwait[0] && !dWEN[0];
            tick();
            if (respond) begin
                cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h600; dstore[0] = 32'h66;
            end
        end
        #1 nRST = 1'b0;
        #1;
        checks++;
        if (hit != 1 || {ramREN, ramWEN, dwait[0], dwait[1], ccwait[0], ccwait[1]} !== 6'b001100) begin
            errors++; $display("FAIL reset_mid got hit=%0d %b exp 1 001100", hit, {ramREN, ramWEN, dwait[0], dwait[1], ccwait[0], ccwait[1]});
        end
        clear_inputs();
        tick();
        nRST = 1'b1;
        ram_lat = 0;
        sb.push_back('{32'h700, 32'h77});
        sb.push_back('{32'h704, 32'h78});
        tick();
        dWEN[0] = 1'b1; daddr[0] = 32'h700; dstore[0] = 32'h77;
        for (int c = 0; c < 20 && words < 2; c++) begin
            @(negedge CLK);
            adv = 1'b0;
            if (ramWEN && first < 0) first = c;
            if (dwait[0] === 1'b0) begin
                e = sb.pop_front();
                checks++;
                if ({ramaddr, ramstore} !== {e.addr, e.data}) begin
                    errors++; $display("FAIL post_reset_word got %h exp %h", {ramaddr, ramstore}, {e.addr, e.data});
                end
                words++;
                adv = 1'b1;
            end
            tick();
            if (adv && words == 1) begin
                daddr[0] = 32'h704; dstore[0] = 32'h78;
            end
            if (adv && words == 2) clear_inputs();
        end
        checks++;
        if (first != 2 || words != 2) begin
            errors++; $display("FAIL post_reset_start got first=%0d words=%0d exp 2 2", first, words);
        end
    endtask

    task automatic test_back_to_back;
        int rounds = 0;
        int wword [2] = '{0, 0};
        logic w, adv;
        int exp_w;
        do_reset();
        ram_lat = 0;
`ifdef ARB_ROUND_ROBIN_EN
        win_q = '{0, 1, 0, 1};
`else
        win_q = '{0, 0, 0, 0};
`endif
        dWEN[0] = 1'b1; daddr[0] = 32'h400; dstore[0] = 32'h401;
        dWEN[1] = 1'b1; daddr[1] = 32'h500; dstore[1] = 32'h501;
        for (int c = 0; c < 60 && rounds < 4; c++) begin
            @(negedge CLK);
            adv = 1'b0;
            w = 1'b0;
            if (ramWEN && !ramwait) begin
                w = (dwait[0] === 1'b0) ? 1'b0 : 1'b1;
                checks++;
                if ({dwait[w], dwait[!w], ramaddr, ramstore} !== {1'b0, 1'b1, daddr[w], daddr[w] + 32'd1}) begin
                    errors++; $display("FAIL arb_word got %h exp %h", {dwait[w], dwait[!w], ramaddr, ramstore}, {1'b0, 1'b1, daddr[w], daddr[w] + 32'd1});
                end
                adv = 1'b1;
                wword[w]++;
                if (wword[w] == 2) begin
                    exp_w = win_q.pop_front();
                    checks++;
                    if (int'(w) != exp_w) begin
                        errors++; $display("FAIL arb_round%0d got %0d exp %0d", rounds, w, exp_w);
                    end
                    wword[w] = 0;
                    rounds++;
                end
            end
            tick();
            if (adv) begin
                daddr[w] = daddr[w] + ((wword[w] == 0) ? 32'hC : 32'h4);
                dstore[w] = daddr[w] + 32'd1;
            end
        end
        checks++;
        if (rounds != 4) begin
            errors++; $display("FAIL arb_done got rounds=%0d exp 4", rounds);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_mem_read();
        test_fwd();
        test_wb();
        test_snoop_delay();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
